// File: rtl/alarm_pkg.sv
// alarm_pkg: shared definitions for the alarm_ctrl slice.
//   STATE_W   - width of the controller state encoding
//   state_t   - controller states (encodings 5..7 are illegal)
//   is_timed  - true for states that run the shared delay counter
package alarm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_t;

  function automatic logic is_timed(input state_t s);
    return (s == ST_EXIT_DLY) || (s == ST_ENTRY_DLY) || (s == ST_ALARM);
  endfunction

endpackage

// File: rtl/alarm_ctrl_btn_sync.sv
// btn_sync: 2-flop synchronizer plus rising-edge detector for one pushbutton.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   btn   - raw asynchronous button level
//   pulse - one-cycle pulse on a synchronized rising edge
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      fill <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
      if (fill != 2'd3) fill <= fill + 2'd1;
    end
  end

  // Edges are only reported once prev holds a real sample taken after reset,
  // so a button held through reset never produces a pulse.
  assign pulse = s2 & ~prev & (fill == 2'd3);

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: intrusion alarm controller with exit/entry delays and a timed
// alarm that automatically re-arms.
//   clk, rst_n     - system clock, asynchronous active-low reset
//   arm_btn        - arm pushbutton (async, active-high)
//   disarm_btn     - disarm pushbutton (async, active-high)
//   sensor[3:0]    - zone sensors (async, 1 = tripped)
//   zone_mask[3:0] - static zone enables (1 = monitored)
//   tamper         - tamper input, present only with TAMPER_ALARM_EN defined
//   aux, siren     - high only in ALARM
//   armed_led      - high in every state except DISARMED
//   zone_latched   - zones that caused the last trip
//   state[2:0]     - current state encoding
// Build option: define TAMPER_ALARM_EN to add the tamper input, which forces
// ALARM from any state.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned EXIT_CYCLES  = 500000000,
  parameter int unsigned ENTRY_CYCLES = 750000000,
  parameter int unsigned ALARM_CYCLES = 1500000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_btn,
  input  logic               disarm_btn,
  input  logic [3:0]         sensor,
  input  logic [3:0]         zone_mask,
`ifdef TAMPER_ALARM_EN
  input  logic               tamper,
`endif
  output logic               aux,
  output logic               siren,
  output logic               armed_led,
  output logic [3:0]         zone_latched,
  output logic [STATE_W-1:0] state
);

  localparam logic [31:0] EXIT_LAST  = 32'(EXIT_CYCLES - 1);
  localparam logic [31:0] ENTRY_LAST = 32'(ENTRY_CYCLES - 1);
  localparam logic [31:0] ALARM_LAST = 32'(ALARM_CYCLES - 1);

  state_t      state_q, state_n;
  logic [31:0] cnt_q, cnt_n;
  logic [3:0]  zl_n;
  logic [3:0]  sens_s1, sens_s2;
  logic [3:0]  trip;
  logic        arm_p, dis_p;
  logic        tamper_hit;
  logic        alarm_n, led_n;

  btn_sync u_arm_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (arm_btn),
    .pulse (arm_p)
  );

  btn_sync u_disarm_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (disarm_btn),
    .pulse (dis_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_s1 <= '0;
      sens_s2 <= '0;
    end else begin
      sens_s1 <= sensor;
      sens_s2 <= sens_s1;
    end
  end

`ifdef TAMPER_ALARM_EN
  logic tamp_s1, tamp_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tamp_s1 <= 1'b0;
      tamp_s2 <= 1'b0;
    end else begin
      tamp_s1 <= tamper;
      tamp_s2 <= tamp_s1;
    end
  end

  assign tamper_hit = tamp_s2;
`else
  assign tamper_hit = 1'b0;
`endif

  assign trip  = sens_s2 & zone_mask;
  assign state = state_q;

  // State register plus the registered counter, zone latch and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DISARMED;
      cnt_q        <= '0;
      zone_latched <= '0;
      aux          <= 1'b0;
      siren        <= 1'b0;
      armed_led    <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      zone_latched <= zl_n;
      aux          <= alarm_n;
      siren        <= alarm_n;
      armed_led    <= led_n;
    end
  end

  // Next state: illegal encodings first, then disarm, then tamper, then the
  // per-state arm / trip / timer rules.
  always_comb begin
    state_n = state_q;
    if (state_q > ST_ALARM) begin
      state_n = ST_DISARMED;
    end else if (dis_p && (state_q != ST_DISARMED)) begin
      state_n = ST_DISARMED;
    end else if (tamper_hit && (state_q != ST_ALARM)) begin
      state_n = ST_ALARM;
    end else begin
      case (state_q)
        ST_DISARMED:  if (arm_p)                state_n = ST_EXIT_DLY;
        ST_EXIT_DLY:  if (cnt_q == EXIT_LAST)   state_n = ST_ARMED;
        ST_ARMED:     if (|trip)                state_n = ST_ENTRY_DLY;
        ST_ENTRY_DLY: if (cnt_q == ENTRY_LAST)  state_n = ST_ALARM;
        ST_ALARM:     if (cnt_q == ALARM_LAST)  state_n = ST_ARMED;
        default:                                state_n = ST_DISARMED;
      endcase
    end
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_n = '0;
    if ((state_n == state_q) && is_timed(state_q)) begin
      cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    end
  end

  always_comb begin
    zl_n = zone_latched;
    if ((state_q == ST_DISARMED) && (state_n == ST_EXIT_DLY)) begin
      zl_n = '0;
    end else if ((state_q == ST_ARMED) && (state_n == ST_ENTRY_DLY)) begin
      zl_n = trip;
    end else if ((state_q == ST_ENTRY_DLY) || (state_q == ST_ALARM)) begin
      zl_n = zone_latched | trip;
    end
  end

  // Outputs decoded from the next state so the registered outputs line up
  // with the state register.
  always_comb begin
    alarm_n = 1'b0;
    led_n   = 1'b0;
    case (state_n)
      ST_ALARM: begin
        alarm_n = 1'b1;
        led_n   = 1'b1;
      end
      ST_EXIT_DLY, ST_ARMED, ST_ENTRY_DLY: led_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter EXIT_CYCLES, default 500000000, clk cycles of exit delay after arming.
REQ-002 SHALL have parameter ENTRY_CYCLES, default 750000000, clk cycles of entry grace after a zone trip.
REQ-003 SHALL have parameter ALARM_CYCLES, default 1500000000, clk cycles the alarm sounds before auto re-arm.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port arm_btn  input  1  asynchronous arm pushbutton, active-high.
REQ-007 SHALL have port disarm_btn  input  1  asynchronous disarm pushbutton, active-high.
REQ-008 SHALL have port sensor  input  4  asynchronous zone sensors, 1 = tripped.
REQ-009 SHALL have port zone_mask  input  4  static zone enables, 1 = zone monitored.
REQ-010 SHALL have port aux  output  1  enable to the LED blinker; 1 only in ALARM.
REQ-011 SHALL have port siren  output  1  siren drive; 1 only in ALARM.
REQ-012 SHALL have port armed_led  output  1  1 in EXIT_DLY, ARMED, ENTRY_DLY, ALARM.
REQ-013 SHALL have port zone_latched  output  4  zones that caused the last trip.
REQ-014 SHALL have port state  output  3  current state encoding.

Function
REQ-015 SHALL pass arm_btn, disarm_btn and each sensor bit through a 2-flop synchronizer; buttons additionally rising-edge detected (one-cycle pulse).
REQ-016 SHALL implement states DISARMED=0, EXIT_DLY=1, ARMED=2, ENTRY_DLY=3, ALARM=4; encodings 5-7 SHALL return to DISARMED next edge.
REQ-017 SHALL go DISARMED -> EXIT_DLY on arm pulse, clearing zone_latched.
REQ-018 SHALL go EXIT_DLY -> ARMED when delay counter reaches EXIT_CYCLES-1; sensors ignored in EXIT_DLY.
REQ-019 SHALL go ARMED -> ENTRY_DLY when (synced sensor & zone_mask) != 0, loading zone_latched with that value.
REQ-020 SHALL OR further masked trips into zone_latched while in ENTRY_DLY and ALARM.
REQ-021 SHALL go ENTRY_DLY -> ALARM when counter reaches ENTRY_CYCLES-1.
REQ-022 SHALL go ALARM -> ARMED when counter reaches ALARM_CYCLES-1, holding zone_latched.
REQ-023 SHALL go to DISARMED from any non-DISARMED state on disarm pulse; disarm SHALL take priority over arm, trip and timer expiry in the same cycle.
REQ-024 SHALL ignore arm pulses in every state except DISARMED.
REQ-025 SHALL use one 32-bit delay counter cleared on every state entry, incrementing each cycle in EXIT_DLY/ENTRY_DLY/ALARM, held at 0 otherwise; no wrap.
REQ-026 SHALL show a button or sensor rising edge on state at the 3rd rising clk edge after it (2 sync + 1 state register).
REQ-027 SHALL register all outputs (Moore, decoded from state register).

Reset
REQ-028 SHALL, on rst_n low, immediately force state=DISARMED, counter=0, zone_latched=0, aux=0, siren=0, armed_led=0, synchronizers and edge registers=0, including mid-delay or mid-alarm.
REQ-029 SHALL resume on the first clk edge after rst_n deasserts; a button held through reset SHALL NOT produce a pulse.

Configuration
REQ-030 SHALL, with TAMPER_ALARM_EN defined, add input tamper (1 bit, synchronized like sensors) forcing ALARM from any state, including DISARMED, with counter cleared; only disarm or reset exit it then, ALARM_CYCLES timeout to ARMED still applying.
REQ-031 SHALL, without TAMPER_ALARM_EN, have no tamper port and identical behaviour otherwise.

Structure
REQ-032 SHALL place state encodings and STATE_W=3 in shared package alarm_pkg.
REQ-033 SHALL use one sub-module btn_sync (2-flop sync + rising-edge pulse, async active-low reset), instantiated per button.

Verification (EXIT=10, ENTRY=20, ALARM=50)
REQ-034 Arm pulse in DISARMED -> state=1 at edge 3, state=2 exactly 10 cycles later, armed_led=1 throughout.
REQ-035 ARMED, zone_mask=4'b0101, sensor=4'b0100 -> state=3, zone_latched=4'b0100; no disarm -> state=4, aux=siren=1 after 20 cycles, state=2 after 50 more.
REQ-036 ARMED, sensor=4'b1010 with mask 4'b0101 -> state stays 2, zone_latched=0.
REQ-037 arm and disarm edges same cycle in ENTRY_DLY -> state=0, outputs 0; sensor tripped during EXIT_DLY -> no ENTRY_DLY.
REQ-038 rst_n low mid-ALARM -> aux=siren=0, state=0 without clk edge; with TAMPER_ALARM_EN, tamper=1 in DISARMED -> state=4 at edge 3.
